// File: rtl/button_event_classifier.sv
// Turns a debounced button level into press/release edges and short/long/double-click gestures.
// Every output is registered one cycle after its edge; there is no backpressure and events are fire-and-forget.
module button_event_classifier #(
  parameter int LONG_TICKS       = 1_200_000,
  parameter int DOUBLE_GAP_TICKS = 3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);

  localparam int MAX_TICKS = (LONG_TICKS > DOUBLE_GAP_TICKS) ? LONG_TICKS : DOUBLE_GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD,
    S_WAIT_SECOND,
    S_SECOND_PRESSED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_q;
  logic             press_q, release_q, short_q, long_q, double_q;
  logic             short_d, long_d, double_d;
  logic             rise, fall;

  assign rise = debounced_in & ~in_q;
  assign fall = ~debounced_in & in_q;

  // Edges are tested before the counter thresholds so a coincident edge always wins.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (fall) begin
          state_d = S_WAIT_SECOND;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG_HELD;
        end
      end
      S_LONG_HELD: begin
        if (fall) state_d = S_IDLE;
      end
      S_WAIT_SECOND: begin
        if (rise) begin
          state_d = S_SECOND_PRESSED;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SECOND_PRESSED: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG_HELD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      in_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_q      <= debounced_in;
      press_q   <= rise;
      release_q <= fall;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign double_click  = double_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier: timestamp-based gesture model plus literal timing checks.
module tb_button_event_classifier;

  localparam int LT = 50;
  localparam int GT = 20;

  logic clk;
  logic rst;
  logic debounced_in;
  logic press_pulse, release_pulse, short_press, long_press, double_click, busy;

  button_event_classifier #(.LONG_TICKS(LT), .DOUBLE_GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .debounced_in(debounced_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .short_press(short_press), .long_press(long_press),
    .double_click(double_click), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Gesture model: phase plus the posedge index of the edge that opened it.
  localparam int G_NONE = 0, G_FIRST = 1, G_GAP = 2, G_SECOND = 3, G_LONG = 4;
  int cyc = 0;
  int g = G_NONE;
  int t0 = 0;
  bit m_prev = 0;
  bit m_rise, m_fall;
  bit e_press, e_rel, e_short, e_long, e_dbl;

  always @(posedge clk) begin
    cyc = cyc + 1;
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_dbl = 0;
    if (!rst) begin
      m_prev = 0;
      g = G_NONE;
    end else begin
      m_rise = debounced_in && !m_prev;
      m_fall = !debounced_in && m_prev;
      m_prev = debounced_in;
      e_press = m_rise;
      e_rel = m_fall;
      case (g)
        G_NONE:   if (m_rise) begin g = G_FIRST; t0 = cyc; end
        G_FIRST:  if (m_fall) begin g = G_GAP; t0 = cyc; end
                  else if (cyc - t0 == LT) begin e_long = 1; g = G_LONG; end
        G_GAP:    if (m_rise) begin g = G_SECOND; t0 = cyc; end
                  else if (cyc - t0 == GT) begin e_short = 1; g = G_NONE; end
        G_SECOND: if (m_fall) begin e_dbl = 1; g = G_NONE; end
                  else if (cyc - t0 == LT) begin e_long = 1; g = G_LONG; end
        default:  if (m_fall) g = G_NONE;
      endcase
    end
  end

  int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_dbl = 0;
  int c_press = 0, c_rel = 0, c_short = 0, c_long = 0, c_dbl = 0;

  always @(negedge clk) begin
    chk("press_pulse",   press_pulse,   rst && e_press);
    chk("release_pulse", release_pulse, rst && e_rel);
    chk("short_press",   short_press,   rst && e_short);
    chk("long_press",    long_press,    rst && e_long);
    chk("double_click",  double_click,  rst && e_dbl);
    chk("busy",          busy,          rst && (g != G_NONE));
    chk("class_onehot",  (int'(short_press) + int'(long_press) + int'(double_click)) <= 1, 1);
    chk("edge_excl",     press_pulse && release_pulse, 0);
    if (press_pulse)   begin n_press++; c_press = cyc; end
    if (release_pulse) begin n_rel++;   c_rel = cyc;   end
    if (short_press)   begin n_short++; c_short = cyc; end
    if (long_press)    begin n_long++;  c_long = cyc;  end
    if (double_click)  begin n_dbl++;   c_dbl = cyc;   end
  end

  int b_press, b_rel, b_short, b_long, b_dbl;

  task automatic snap();
    b_press = n_press; b_rel = n_rel; b_short = n_short; b_long = n_long; b_dbl = n_dbl;
  endtask

  task automatic hold(input bit v, input int n);
    debounced_in = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int c0;
  int gap;

  initial begin
    rst = 1'b0;
    debounced_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_busy", busy, 0);
    chk("reset_press", press_pulse, 0);
    snap();
    rst = 1'b1;
    c0 = cyc;
    hold(1, 5);
    chk("rst_rel_press_cnt", n_press - b_press, 1);
    chk("rst_rel_press_cyc", c_press, c0 + 1);
    hold(0, 40);

    // short press
    snap();
    hold(1, 10);
    hold(0, 40);
    chk("short_press_cnt", n_press - b_press, 1);
    chk("short_rel_cnt", n_rel - b_rel, 1);
    chk("short_cnt", n_short - b_short, 1);
    chk("short_delay", c_short - c_rel, GT);
    chk("short_no_long", n_long - b_long, 0);
    chk("short_no_dbl", n_dbl - b_dbl, 0);

    // long press
    snap();
    hold(1, 80);
    chk("long_delay", c_long - c_press, LT);
    hold(0, 100);
    chk("long_cnt", n_long - b_long, 1);
    chk("long_rel_cnt", n_rel - b_rel, 1);
    chk("long_no_short", n_short - b_short, 0);

    // double click
    snap();
    hold(1, 10); hold(0, 8); hold(1, 10); hold(0, 40);
    chk("dbl_press_cnt", n_press - b_press, 2);
    chk("dbl_rel_cnt", n_rel - b_rel, 2);
    chk("dbl_cnt", n_dbl - b_dbl, 1);
    chk("dbl_on_release", c_dbl, c_rel);
    chk("dbl_no_short", n_short - b_short, 0);

    // gap boundary: second rise GT and GT+1 posedges after the release
    snap();
    hold(1, 10); hold(0, GT); hold(1, 10); hold(0, 40);
    chk("gap_last_dbl", n_dbl - b_dbl, 1);
    chk("gap_last_short", n_short - b_short, 0);
    snap();
    hold(1, 10); hold(0, GT + 1); hold(1, 10); hold(0, 40);
    chk("gap_over_dbl", n_dbl - b_dbl, 0);
    chk("gap_over_short", n_short - b_short, 2);

    // mid-gesture reset
    snap();
    debounced_in = 1'b1;
    repeat (30) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_press", press_pulse, 0);
    debounced_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    hold(0, 60);
    chk("midrst_no_long", n_long - b_long, 0);
    chk("midrst_busy", busy, 0);
    snap();
    hold(1, 10); hold(0, 40);
    chk("midrst_next_short", n_short - b_short, 1);

    // random gestures, occasional reset
    for (int i = 0; i < 60; i++) begin
      hold(1, $urandom_range(1, 70));
      gap = $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        hold(0, 2);
        rst = 1'b1;
      end
      hold(0, gap);
    end
    hold(0, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
